median_frame_sequencer: RTL and testbench

//  Frame-level controller in front of median_5x5_top_module.
//  - Waits for SOF (tuser) and latches WIDTH/HEIGHT per frame.
//  - Regenerates tuser/tlast from its own column/row counters and flags malformed input lines.
//  - After the last pixel, injects KERNEL_SIZE/2 flush lines so the median line buffers drain the frame tail.

---
 rtl/median_pkg.sv | 19 +
 rtl/median_seq_pos_counter.sv | 48 ++++
 rtl/median_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_median_frame_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared state encoding, error bit positions and default sizing for the
// median frame sequencer and its position counter.
package median_pkg;

  localparam int DIM_WIDTH_DEF = 12;

  localparam int ERR_TLAST     = 0;
  localparam int ERR_EARLY_SOF = 1;
  localparam int ERR_CFG       = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    FLUSH,
    DONE
  } seq_state_t;

endpackage

// File: rtl/median_seq_pos_counter.sv
// Column/row position counter: load to (0,0) or (1,0), advance on accepted
// beats, wrap at the latched width/height, flag end of line / end of frame.
module median_seq_pos_counter
  import median_pkg::*;
#(
  parameter int DIM_WIDTH = DIM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 inc,
  input  logic [DIM_WIDTH-1:0] width,
  input  logic [DIM_WIDTH-1:0] height,
  output logic                 eol,
  output logic                 eof
);

  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  logic [DIM_WIDTH-1:0] col;
  logic [DIM_WIDTH-1:0] row;

  assign eol = (col == width - ONE);
  assign eof = (row == height - ONE);

  // start means the SOF beat itself was consumed, so the next beat sits at column 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= ONE;
      row <= '0;
    end else if (inc) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

endmodule

// File: rtl/median_frame_sequencer.sv
// Frame controller ahead of the median core: SOF sync, tuser/tlast regeneration,
// error flags and tail flush. MEDIAN_SEQ_FLUSH_HOLD_EN: flush repeats last pixel.
//
// state    | meaning
// IDLE     | stopped, input not accepted
// WAIT_SOF | dropping beats until a valid start of frame
// ACTIVE   | forwarding pixels of the current frame
// FLUSH    | emitting KERNEL_SIZE/2 synthetic lines to drain the line buffers
// DONE     | single-cycle frame completion pulse
module median_frame_sequencer
  import median_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int DIM_WIDTH   = DIM_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_enable,
  input  logic [DIM_WIDTH-1:0]  i_width,
  input  logic [DIM_WIDTH-1:0]  i_height,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [2:0]            o_err,
  input  logic                  i_err_clr
);

  localparam int FLUSH_ROWS = KERNEL_SIZE / 2;
  localparam int FCW        = DIM_WIDTH + $clog2(FLUSH_ROWS + 1);
  localparam logic [DIM_WIDTH-1:0] K_DIM        = DIM_WIDTH'(KERNEL_SIZE);
  localparam logic [FCW-1:0]       FLUSH_ROWS_C = FCW'(FLUSH_ROWS);

  seq_state_t            state, state_nxt;
  logic [DIM_WIDTH-1:0]  width_q, height_q;
  logic [FCW-1:0]        flush_cnt;
  logic [DATA_WIDTH-1:0] flush_data;
  logic                  load_ok, s_acc, sof_in, cfg_ok, sof_ok;
  logic                  pix_acc, last_active, flush_acc, flush_last;
  logic                  eol, eof;
  logic [2:0]            err_set;

  assign load_ok     = !m_axis_tvalid || m_axis_tready;
  assign s_acc       = s_axis_tvalid && s_axis_tready;
  assign sof_in      = s_acc && s_axis_tuser;
  assign cfg_ok      = (i_width >= K_DIM) && (i_height >= K_DIM);
  assign sof_ok      = sof_in && cfg_ok;
  assign pix_acc     = s_acc && !s_axis_tuser && (state == ACTIVE);
  assign last_active = pix_acc && eol && eof;
  assign flush_acc   = (state == FLUSH) && load_ok;
  assign flush_last  = flush_acc && (flush_cnt == '0);

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_enable) state_nxt = WAIT_SOF;
      WAIT_SOF: begin
        if (sof_ok)         state_nxt = ACTIVE;
        else if (!i_enable) state_nxt = IDLE;
      end
      ACTIVE: begin
        if (sof_in && !cfg_ok) state_nxt = WAIT_SOF;
        else if (last_active)  state_nxt = FLUSH;
      end
      FLUSH:    if (flush_last) state_nxt = DONE;
      DONE:     state_nxt = i_enable ? WAIT_SOF : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A SOF waiting for a stalled output register is held, everything else is dropped freely
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      WAIT_SOF: s_axis_tready = !(s_axis_tuser && !load_ok);
      ACTIVE:   s_axis_tready = load_ok;
      default:  s_axis_tready = 1'b0;
    endcase
    o_busy       = (state != IDLE);
    o_frame_done = (state == DONE);
  end

  median_seq_pos_counter #(
    .DIM_WIDTH(DIM_WIDTH)
  ) u_pos (
    .clk   (i_clk),
    .rst_n (i_aresetn),
    .clear (last_active),
    .start (sof_ok),
    .inc   (pix_acc || flush_acc),
    .width (width_q),
    .height(height_q),
    .eol   (eol),
    .eof   (eof)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      width_q  <= '0;
      height_q <= '0;
    end else if (sof_ok) begin
      width_q  <= i_width;
      height_q <= i_height;
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)       flush_cnt <= '0;
    else if (last_active) flush_cnt <= FLUSH_ROWS_C * FCW'(width_q) - FCW'(1);
    else if (flush_acc)   flush_cnt <= flush_cnt - FCW'(1);
  end

`ifdef MEDIAN_SEQ_FLUSH_HOLD_EN
  logic [DATA_WIDTH-1:0] last_pix;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)              last_pix <= '0;
    else if (sof_ok || pix_acc)  last_pix <= s_axis_tdata;
  end

  assign flush_data = last_pix;
`else
  assign flush_data = '0;
`endif

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load_ok) begin
      if (sof_ok) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tuser  <= 1'b1;
        m_axis_tlast  <= 1'b0;
      end else if (pix_acc) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= eol;
      end else if (state == FLUSH) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= flush_data;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= eol;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    err_set                = '0;
    err_set[ERR_TLAST]     = pix_acc && (s_axis_tlast != eol);
    err_set[ERR_EARLY_SOF] = sof_in && (state == ACTIVE);
    err_set[ERR_CFG]       = sof_in && !cfg_ok;
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)     o_err <= '0;
    else if (i_err_clr) o_err <= '0;
    else                o_err <= o_err | err_set;
  end

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Directed self-checking bench for median_frame_sequencer (KERNEL_SIZE=5).
module tb_median_frame_sequencer;

  localparam int DW = 8;
  localparam int KS = 5;
  localparam int DIMW = 12;

`ifdef MEDIAN_SEQ_FLUSH_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [DIMW-1:0] width = 12'd8;
  logic [DIMW-1:0] height = 12'd6;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic            s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tuser, m_tlast;
  logic            m_tready = 1'b1;
  logic            busy, frame_done;
  logic [2:0]      err;
  logic            err_clr = 1'b0;

  always #5 clk = ~clk;

  median_frame_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .DIM_WIDTH(DIMW)) dut (
    .i_clk(clk), .i_aresetn(rst_n), .i_enable(enable),
    .i_width(width), .i_height(height),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .o_busy(busy), .o_frame_done(frame_done), .o_err(err), .i_err_clr(err_clr)
  );

  int         tests = 0;
  int         fails = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int         done_cnt = 0;
  int         stall_bad = 0;
  bit         stall_chk = 1'b0;
  bit         toggle_mode = 1'b0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  initial forever begin
    @(posedge clk); #1;
    if (toggle_mode) m_tready = ~m_tready;
    else             m_tready = 1'b1;
  end

  // Output monitor: a beat counts when valid&ready is seen mid-cycle
  initial forever begin
    @(negedge clk);
    if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tuser, m_tlast});
    if (frame_done) done_cnt++;
    if (stall_chk && prev_stall && (!m_tvalid || {m_tdata, m_tuser, m_tlast} != prev_beat))
      stall_bad++;
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tdata, m_tuser, m_tlast};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clr_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    stall_bad = 0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    bit acc;
    acc = 1'b0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_beat_timeout: tready stayed 0, required 1");
    end
  endtask

  // n beats of a raster frame; input tlast moved from col bad_idx+1 to bad_idx
  task automatic send_frame(input int w, input int n, input int base, input int bad_idx);
    logic l;
    for (int p = 0; p < n; p++) begin
      l = ((p % w) == w - 1);
      if (p == bad_idx) l = 1'b1;
      if (p == bad_idx + 1) l = 1'b0;
      send_beat(8'(base + p), (p == 0), l);
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  function automatic void exp_frame(input int w, input int n, input int base);
    for (int p = 0; p < n; p++)
      exp_q.push_back({8'(base + p), 1'(p == 0), 1'((p % w) == w - 1)});
  endfunction

  function automatic void exp_flush(input int w, input logic [7:0] val);
    for (int f = 0; f < (KS / 2) * w; f++)
      exp_q.push_back({val, 1'b0, 1'((f % w) == w - 1)});
  endfunction

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt < 1; i++) cycles(1);
    cycles(6);
    tests++;
    if (done_cnt < 1) begin
      fails++;
      $display("FAIL wait_done_timeout: frame_done count %0d after %0d cycles, required 1", done_cnt, max);
    end
  endtask

  task automatic test_reset();
    cycles(2);
    tests++;
    if ({m_tvalid, m_tuser, m_tlast, s_tready, busy, frame_done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 000000", {m_tvalid, m_tuser, m_tlast, s_tready, busy, frame_done});
    end
    tests++;
    if (m_tdata !== 8'h00 || err !== 3'b000) begin
      fails++;
      $display("FAIL reset_data_err: data %h err %b, required 00 000", m_tdata, err);
    end
    rst_n = 1'b1;
    cycles(3);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
    enable = 1'b1;
    cycles(2);
    tests++;
    if (busy !== 1'b1 || s_tready !== 1'b1) begin
      fails++;
      $display("FAIL enable_wait_sof: busy %b tready %b, required 1 1", busy, s_tready);
    end
  endtask

  task automatic test_clean_frame();
    clr_mon();
    send_frame(8, 48, 1, -10);
    wait_done(200);
    exp_frame(8, 48, 1);
    exp_flush(8, HOLD ? 8'd48 : 8'd0);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL clean_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL clean_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if (done_cnt != 1 || err !== 3'b000) begin
      fails++;
      $display("FAIL clean_done_err: done %0d err %b, required 1 000", done_cnt, err);
    end
  endtask

  task automatic test_stall();
    clr_mon();
    toggle_mode = 1'b1;
    stall_chk   = 1'b1;
    send_frame(8, 48, 1, -10);
    wait_done(400);
    toggle_mode = 1'b0;
    stall_chk   = 1'b0;
    cycles(2);
    exp_frame(8, 48, 1);
    exp_flush(8, HOLD ? 8'd48 : 8'd0);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL stall_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stall_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if (stall_bad != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL stall_hold: unstable beats %0d done %0d, required 0 1", stall_bad, done_cnt);
    end
  endtask

  task automatic test_tlast_mismatch();
    clear_err();
    clr_mon();
    send_frame(8, 48, 1, 22);
    wait_done(200);
    exp_frame(8, 48, 1);
    exp_flush(8, HOLD ? 8'd48 : 8'd0);
    tests++;
    if (err !== 3'b001) begin
      fails++;
      $display("FAIL tlast_err: got %b, required 001", err);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL tlast_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL tlast_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_early_sof();
    clear_err();
    clr_mon();
    send_frame(8, 20, 1, -10);
    send_frame(8, 48, 101, -10);
    wait_done(200);
    exp_frame(8, 20, 1);
    exp_frame(8, 48, 101);
    exp_flush(8, HOLD ? 8'd148 : 8'd0);
    tests++;
    if (err !== 3'b010 || done_cnt != 1) begin
      fails++;
      $display("FAIL early_sof_err_done: err %b done %0d, required 010 1", err, done_cnt);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL early_sof_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL early_sof_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_config();
    clear_err();
    clr_mon();
    width = 12'd4;
    send_frame(4, 4, 1, -10);
    cycles(4);
    tests++;
    if (got_q.size() != 0 || err !== 3'b100) begin
      fails++;
      $display("FAIL badcfg_drop: beats %0d err %b, required 0 100", got_q.size(), err);
    end
    tests++;
    if (busy !== 1'b1 || s_tready !== 1'b1) begin
      fails++;
      $display("FAIL badcfg_wait_sof: busy %b tready %b, required 1 1", busy, s_tready);
    end
    width = 12'd8;
    send_frame(8, 48, 1, -10);
    wait_done(200);
    tests++;
    if (got_q.size() != 64 || done_cnt != 1 || err !== 3'b100) begin
      fails++;
      $display("FAIL badcfg_recover: beats %0d done %0d err %b, required 64 1 100", got_q.size(), done_cnt, err);
    end
    clear_err();
    tests++;
    if (err !== 3'b000) begin
      fails++;
      $display("FAIL err_clear: got %b, required 000", err);
    end
  endtask

  task automatic test_reset_flush();
    clr_mon();
    send_frame(8, 48, 43, -10);
    cycles(3);
    @(negedge clk);
    tests++;
    if (m_tvalid !== 1'b1 || m_tuser !== 1'b0 || m_tdata !== (HOLD ? 8'h5A : 8'h00)) begin
      fails++;
      $display("FAIL flush_data: valid %b user %b data %h, required 1 0 %h", m_tvalid, m_tuser, m_tdata, HOLD ? 8'h5A : 8'h00);
    end
    tests++;
    if (busy !== 1'b1 || s_tready !== 1'b0) begin
      fails++;
      $display("FAIL flush_state: busy %b tready %b, required 1 0", busy, s_tready);
    end
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    tests++;
    if ({m_tvalid, m_tuser, m_tlast, s_tready, busy, frame_done} !== 6'b0 || m_tdata !== 8'h00 || err !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: ctrl %b data %h err %b, required 000000 00 000",
               {m_tvalid, m_tuser, m_tlast, s_tready, busy, frame_done}, m_tdata, err);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    tests++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      fails++;
      $display("FAIL post_reset_idle: busy %b done %0d, required 0 0", busy, done_cnt);
    end
    enable = 1'b1;
    cycles(2);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_enable: busy %b, required 1", busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_stall();
    test_tlast_mismatch();
    test_early_sof();
    test_bad_config();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
